mac_window_scheduler: RTL and testbench
=======================================

Name: mac_window_scheduler

Overview:
- Shares one multiplier plus 15-tap accumulator chain between two pixel-window requesters.
- Arbitrates round-robin at window granularity. A granted window's 15 taps (3 rows x 5 cols) are issued on consecutive cycles, because the accumulator counts contiguous groups of 15.
- Tracks the owner of each in-flight window in a tag FIFO and routes each accumulated result back to its owner.
- Sits between the line-buffer/coefficient fetch logic and the multiply/accumulate datapath.

Parameters:
ADDR_W, 16, pixel address width
LINE_W, 640, pixels per image line; row stride for tap addressing
TAGS, 4, maximum windows in flight (tag FIFO depth, power of 2, >=2)

Ports:
clk  in  1  system clock
resetn  in  1  asynchronous active-low reset
req_valid  in  2  window request per requester; held until accepted
req_base  in  2*ADDR_W  top-left pixel address; requester r in bits [r*ADDR_W +: ADDR_W]
req_ready  out  2  one-cycle accept pulse per requester
tap_valid  out  1  tap issue strobe to multiplier (feeds accumulator mult_valid after multiplier latency)
tap_idx  out  4  tap number 0..14 (coefficient index)
tap_coef_sel  out  1  requester id of current window (coefficient bank select)
tap_pix_addr  out  ADDR_W  pixel address of current tap
acc_valid  in  1  accumulator result strobe
acc_data  in  32  accumulated result
res_valid  out  2  result strobe per requester
res_data  out  32  result data, shared by both requesters
busy  out  1  window issuing or tags outstanding
err_orphan  out  1  sticky: acc_valid arrived with no outstanding tag

Behaviour:
- Reset (async, resetn=0):
  - All outputs are 0.
  - FSM=IDLE, tag FIFO empty, last_grant=1, so requester 0 wins the first tie.
- FSM states:
  - IDLE: no taps issued.
  - ISSUE: tap_valid=1 every cycle; tap_idx runs 0..14.
- Grant opportunity occurs in IDLE, and in ISSUE on the cycle tap_idx==14.
  - Condition: any req_valid=1 and tag count < TAGS. Pop credit is not counted, so full stays conservative.
  - Winner: if both requesters are valid, the one != last_grant; otherwise the single valid requester.
  - In the grant cycle: pulse req_ready[winner]; latch req_base[winner] and winner id; push winner id into tag FIFO; last_grant <= winner.
  - Next cycle: tap 0 issued, FSM=ISSUE.
  - Back-to-back windows therefore have no bubble.
- Without a grant, ISSUE returns to IDLE after tap 14.
- Tap addressing uses row 0..2 and col 0..4 counters, advanced incrementally with no multiply or divide:
  - tap_pix_addr = base + row*LINE_W + col, modulo 2^ADDR_W (wraps silently).
  - tap_idx = row*5 + col.
  - col wraps 4->0 and increments row.
- Latency: request accepted in cycle N; tap k issued in cycle N+1+k.
- Result return on acc_valid:
  - Pop the tag FIFO.
  - Next cycle: res_valid[tag]=1 for exactly one cycle; res_data=acc_data (registered).
  - Results return in issue order. There is no result backpressure, so requesters must always accept.
- Tag FIFO:
  - Push and pop in the same cycle are legal; count stays the same.
  - Full blocks grants only.
  - Empty plus acc_valid sets err_orphan, produces no res_valid, and leaves the FIFO unchanged.
- busy = (FSM==ISSUE) | (tag count != 0).
- err_orphan clears only on reset.
- Reset mid-window: abandons in-flight taps and tags. The accumulator has no reset of its own, so the integration must assert resetn for it in parallel or only at a window boundary. The bench checks the controller side only.

Decomposition:
- Shared package (mac_sched_pkg) holds:
  - TAPS=15, KROWS=3, KCOLS=5.
  - Requester-id width.
- Natural sub-module: mac_tag_fifo, a TAGS-deep, 1-bit-wide synchronous FIFO.
  - Outputs: count, full, empty.
  - Async active-low reset.
- The FSM, arbiter and address generator stay in the top module.

Test Plan:
- Single request: req0 with base=100, LINE_W=640 -> req_ready[0] pulses once; taps 0..14 on the next 15 cycles; addresses 100..104, 740..744, 1380..1384; tap_coef_sel=0.
- Both requesters held valid: grant order 0,1,0,1. Tap 0 of each new window follows tap 14 of the previous with no bubble.
- Tag full (TAGS=4, no acc_valid): exactly 4 windows accepted; 5th req_ready stays 0 until one acc_valid, then grant at the next opportunity.
- Result routing: issue windows r0,r1,r0; drive acc_valid with 11,22,33 -> res_valid[0] with 11, res_valid[1] with 22, res_valid[0] with 33, each one cycle after its acc_valid.
- Simultaneous push/pop: grant coinciding with acc_valid keeps count unchanged; the routed result goes to the oldest tag.
- Edge cases:
  - acc_valid with empty FIFO -> err_orphan=1 and no res_valid.
  - base=0xFFFE -> address wraps to 0x0000 with no error.
  - resetn pulsed mid-ISSUE -> all outputs 0 immediately; busy=0.

Source files
------------

// File: rtl/mac_sched_pkg.sv
// mac_sched_pkg: shared window geometry, requester-id width and FSM states
package mac_sched_pkg;
  localparam int TAPS  = 15;
  localparam int KROWS = 3;
  localparam int KCOLS = 5;
  localparam int RID_W = 1;
  typedef enum logic {IDLE, ISSUE} state_t;
endpackage

// File: rtl/mac_tag_fifo.sv
// mac_tag_fifo: owner-id FIFO for in-flight windows, results pop in issue order
module mac_tag_fifo
  import mac_sched_pkg::*;
#(
  parameter int TAGS = 4,
  localparam int PW = $clog2(TAGS)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push,
  input  logic [RID_W-1:0] din,
  input  logic             pop,
  output logic [RID_W-1:0] dout,
  output logic [PW:0]      count,
  output logic             full,
  output logic             empty
);
  logic [RID_W-1:0] mem_q [TAGS];
  logic [RID_W-1:0] mem_d [TAGS];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [PW:0] cnt_q, cnt_d;
  logic do_push, do_pop;
  assign full    = cnt_q == (PW+1)'(TAGS);
  assign empty   = cnt_q == '0;
  assign count   = cnt_q;
  assign dout    = mem_q[rd_q];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  always_comb begin
    mem_d = mem_q;
    if (do_push) mem_d[wr_q] = din;
    wr_d  = wr_q + PW'(do_push);
    rd_d  = rd_q + PW'(do_pop);
    cnt_d = cnt_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mem_q <= '{default: '0};
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/mac_window_scheduler.sv
// mac_window_scheduler: round-robin window arbiter, 15-tap address issuer and
// result router sharing one MAC chain between two requesters
module mac_window_scheduler
  import mac_sched_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int LINE_W = 640,
  parameter int TAGS   = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [1:0]        req_valid,
  input  logic [2*ADDR_W-1:0] req_base,
  output logic [1:0]        req_ready,
  output logic              tap_valid,
  output logic [3:0]        tap_idx,
  output logic              tap_coef_sel,
  output logic [ADDR_W-1:0] tap_pix_addr,
  input  logic              acc_valid,
  input  logic [31:0]       acc_data,
  output logic [1:0]        res_valid,
  output logic [31:0]       res_data,
  output logic              busy,
  output logic              err_orphan
);
  localparam int CW = $clog2(TAGS) + 1;
  localparam logic [ADDR_W-1:0] LW = ADDR_W'(LINE_W);
  state_t state_q, state_d;
  logic [1:0] row_q, row_d;
  logic [2:0] col_q, col_d;
  logic [ADDR_W-1:0] row_addr_q, row_addr_d, addr_q, addr_d, win_base;
  logic sel_q, sel_d, last_q, last_d, err_q, err_d;
  logic [1:0] res_valid_q, res_valid_d;
  logic [31:0] res_data_q, res_data_d;
  logic tag_out, tag_full, tag_empty;
  logic [CW-1:0] tag_cnt;
  logic last_tap, opp, grant, win, pop;
  assign last_tap = row_q == 2'(KROWS-1) && col_q == 3'(KCOLS-1);
  assign opp      = state_q == IDLE || last_tap;
  // full is judged on the registered count; a same-cycle pop earns no credit
  assign grant    = resetn & opp & |req_valid & ~tag_full;
  assign win      = &req_valid ? ~last_q : req_valid[1];
  assign win_base = win ? req_base[2*ADDR_W-1:ADDR_W] : req_base[ADDR_W-1:0];
  assign pop      = acc_valid & ~tag_empty;
  mac_tag_fifo #(.TAGS(TAGS)) u_tags (
    .clk(clk), .resetn(resetn), .push(grant), .din(win), .pop(pop),
    .dout(tag_out), .count(tag_cnt), .full(tag_full), .empty(tag_empty)
  );
  always_comb begin
    state_d     = grant ? ISSUE : (last_tap ? IDLE : state_q);
    row_d       = row_q;
    col_d       = col_q;
    row_addr_d  = row_addr_q;
    addr_d      = addr_q;
    sel_d       = grant ? win : sel_q;
    last_d      = grant ? win : last_q;
    if (grant) begin
      row_d      = '0;
      col_d      = '0;
      row_addr_d = win_base;
      addr_d     = win_base;
    end else if (state_q == ISSUE && !last_tap) begin
      // row stride applied incrementally so no multiplier is needed
      col_d      = col_q == 3'(KCOLS-1) ? '0 : col_q + 3'd1;
      row_d      = col_q == 3'(KCOLS-1) ? row_q + 2'd1 : row_q;
      row_addr_d = col_q == 3'(KCOLS-1) ? row_addr_q + LW : row_addr_q;
      addr_d     = col_q == 3'(KCOLS-1) ? row_addr_q + LW : addr_q + 1'b1;
    end
    res_valid_d = pop ? (tag_out ? 2'b10 : 2'b01) : 2'b00;
    res_data_d  = pop ? acc_data : res_data_q;
    err_d       = err_q | (acc_valid & tag_empty);
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      row_q       <= '0;
      col_q       <= '0;
      row_addr_q  <= '0;
      addr_q      <= '0;
      sel_q       <= 1'b0;
      last_q      <= 1'b1;
      res_valid_q <= '0;
      res_data_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      col_q       <= col_d;
      row_addr_q  <= row_addr_d;
      addr_q      <= addr_d;
      sel_q       <= sel_d;
      last_q      <= last_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      err_q       <= err_d;
    end
  end
  assign req_ready    = grant ? (win ? 2'b10 : 2'b01) : 2'b00;
  assign tap_valid    = state_q == ISSUE;
  assign tap_idx      = {row_q, 2'b00} + {2'b00, row_q} + {1'b0, col_q};
  assign tap_coef_sel = sel_q;
  assign tap_pix_addr = addr_q;
  assign res_valid    = res_valid_q;
  assign res_data     = res_data_q;
  assign busy         = tap_valid | (tag_cnt != '0);
  assign err_orphan   = err_q;
endmodule

// File: tb/tb_mac_window_scheduler.sv
// tb_mac_window_scheduler: scoreboard bench for the window scheduler
module tb_mac_window_scheduler;
  logic clk = 1'b0;
  logic resetn;
  logic [1:0] req_valid, req_ready, res_valid;
  logic [31:0] req_base, acc_data, res_data;
  logic tap_valid, tap_coef_sel, acc_valid, busy, err_orphan;
  logic [3:0] tap_idx;
  logic [15:0] tap_pix_addr;
  typedef struct {logic [3:0] idx; logic sel; logic [15:0] addr;} tap_t;
  tap_t taps[$];
  logic tags[$];
  int pend[2];
  logic [15:0] base[2];
  logic last_m, err_m;
  logic [1:0] exp_rv;
  logic [31:0] exp_rd;
  int pass_cnt = 0, total_cnt = 0;
  always #5 clk = ~clk;
  mac_window_scheduler #(.ADDR_W(16), .LINE_W(640), .TAGS(4)) dut (
    .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_base(req_base),
    .req_ready(req_ready), .tap_valid(tap_valid), .tap_idx(tap_idx),
    .tap_coef_sel(tap_coef_sel), .tap_pix_addr(tap_pix_addr),
    .acc_valid(acc_valid), .acc_data(acc_data), .res_valid(res_valid),
    .res_data(res_data), .busy(busy), .err_orphan(err_orphan)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask
  task automatic step(input logic av, input logic [31:0] ad);
    int cur;
    logic g, w;
    logic [1:0] rv;
    @(negedge clk);
    rv = {pend[1] > 0, pend[0] > 0};
    req_valid = rv;
    req_base = {base[1], base[0]};
    acc_valid = av;
    acc_data = ad;
    #1;
    cur = taps.size();
    g = cur <= 1 && rv != 2'b00 && tags.size() < 4;
    w = (rv == 2'b11) ? ~last_m : rv[1];
    chk("req_ready", req_ready, g ? (w ? 2 : 1) : 0);
    chk("tap_valid", tap_valid, cur > 0);
    if (cur > 0) begin
      chk("tap_idx", tap_idx, taps[0].idx);
      chk("tap_coef_sel", tap_coef_sel, taps[0].sel);
      chk("tap_pix_addr", tap_pix_addr, taps[0].addr);
    end
    chk("res_valid", res_valid, exp_rv);
    if (exp_rv != 2'b00) chk("res_data", res_data, exp_rd);
    chk("busy", busy, cur > 0 || tags.size() > 0);
    chk("err_orphan", err_orphan, err_m);
    exp_rv = 2'b00;
    if (av) begin
      if (tags.size() == 0) err_m = 1'b1;
      else begin
        exp_rv = tags.pop_front() ? 2'b10 : 2'b01;
        exp_rd = ad;
      end
    end
    if (cur > 0) void'(taps.pop_front());
    if (g) begin
      tags.push_back(w);
      last_m = w;
      pend[w]--;
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 5; c++)
          taps.push_back('{idx: 4'(r*5 + c), sel: w, addr: base[w] + 16'(r*640 + c)});
    end
  endtask
  task automatic rst_chk();
    @(negedge clk);
    req_valid = 2'b11;
    resetn = 1'b0;
    #1;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_tap_valid", tap_valid, 0);
    chk("rst_tap_idx", tap_idx, 0);
    chk("rst_tap_coef_sel", tap_coef_sel, 0);
    chk("rst_tap_pix_addr", tap_pix_addr, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_data", res_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err_orphan", err_orphan, 0);
    taps.delete();
    tags.delete();
    exp_rv = 2'b00;
    err_m = 1'b0;
    last_m = 1'b1;
    pend = '{0, 0};
    req_valid = 2'b00;
    acc_valid = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
  endtask
  initial begin
    resetn = 1'b0;
    req_valid = '0;
    req_base = '0;
    acc_valid = 1'b0;
    acc_data = '0;
    pend = '{0, 0};
    base = '{16'd0, 16'd0};
    last_m = 1'b1;
    err_m = 1'b0;
    exp_rv = 2'b00;
    exp_rd = '0;
    rst_chk();
    // single window from requester 0
    base[0] = 16'd100;
    pend[0] = 1;
    repeat (17) step(1'b0, 0);
    step(1'b1, 32'h5);
    step(1'b0, 0);
    // both requesters, back-to-back, tag FIFO fills, wrap at 0xFFFE
    base[0] = 16'd200;
    base[1] = 16'hFFFE;
    pend[0] = 3;
    pend[1] = 2;
    repeat (70) step(1'b0, 0);
    step(1'b1, 32'd11);
    repeat (20) step(1'b0, 0);
    // grant and pop in the same idle cycle
    pend[1] = 1;
    step(1'b1, 32'd22);
    repeat (16) step(1'b0, 0);
    step(1'b1, 32'd33);
    step(1'b1, 32'd44);
    step(1'b1, 32'd55);
    step(1'b0, 0);
    // orphan result
    step(1'b1, 32'd66);
    repeat (2) step(1'b0, 0);
    // routing r0, r1, r0
    base[0] = 16'd1000;
    base[1] = 16'd2000;
    pend[0] = 2;
    pend[1] = 1;
    repeat (50) step(1'b0, 0);
    step(1'b1, 32'd11);
    step(1'b1, 32'd22);
    step(1'b1, 32'd33);
    repeat (2) step(1'b0, 0);
    // reset in the middle of a window
    pend[0] = 1;
    repeat (6) step(1'b0, 0);
    rst_chk();
    repeat (3) step(1'b0, 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
